// File: rtl/ysyx_220066_storebuf_if.sv
// Store-side and memory-side channels of the store buffer.
// Handshake rule for both channels: a transfer occurs on a rising clk edge where valid && ready;
// once valid is raised, the payload holds stable until that transfer, and ready never waits on valid.
interface ysyx_220066_storebuf_if #(
  parameter int XLEN = 64,
  parameter int AW   = 64
);
  logic              st_valid;
  logic              st_ready;
  logic [AW-1:0]     st_addr;
  logic [2:0]        st_op;
  logic [XLEN-1:0]   st_data;
  logic              st_misalign;
  logic              mem_valid;
  logic              mem_ready;
  logic [AW-1:0]     mem_addr;
  logic [XLEN-1:0]   mem_data;
  logic [XLEN/8-1:0] mem_mask;

  modport master (
    output st_valid, st_addr, st_op, st_data, mem_ready,
    input  st_ready, st_misalign, mem_valid, mem_addr, mem_data, mem_mask
  );

  modport slave (
    input  st_valid, st_addr, st_op, st_data, mem_ready,
    output st_ready, st_misalign, mem_valid, mem_addr, mem_data, mem_mask
  );
endinterface

// File: rtl/ysyx_220066_storebuf.sv
// In-order store buffer: aligns stores onto the data bus, queues them, drains them to memory,
// flags misaligned stores and reports address overlap with the load in MEM.
module ysyx_220066_storebuf #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4,
  parameter int AW    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  ysyx_220066_storebuf_if.slave    bus,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_conflict,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int NB = XLEN / 8;
  localparam int LB = $clog2(NB);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [LB-1:0]   lane;
  logic [1:0]      szc;
  logic [7:0]      mask8;
  logic            too_big;
  logic            lane_bad;
  logic            illegal;
  logic [NB-1:0]   req_mask;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] req_data;
  logic [AW-1:0]   req_addr;

  // Request decode: size/lane legality, byte mask and lane-shifted data with unused bytes zeroed.
  always_comb begin
    lane    = bus.st_addr[LB-1:0];
    szc     = bus.st_op[1:0];
    too_big = (XLEN == 32) && (szc == 2'b11);
    case (szc)
      2'b00:   begin mask8 = 8'h01; lane_bad = 1'b0;         end
      2'b01:   begin mask8 = 8'h03; lane_bad = lane[0];      end
      2'b10:   begin mask8 = 8'h0f; lane_bad = |lane[1:0];   end
      default: begin mask8 = 8'hff; lane_bad = |lane;        end
    endcase
    illegal  = too_big || lane_bad;
    req_mask = NB'(mask8) << lane;
    shifted  = bus.st_data << {lane, 3'b000};
    req_data = '0;
    for (int i = 0; i < NB; i++) begin
      req_data[8*i +: 8] = req_mask[i] ? shifted[8*i +: 8] : 8'h00;
    end
    req_addr = {bus.st_addr[AW-1:LB], {LB{1'b0}}};
  end

  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [DEPTH-1:0] vld;
  logic            misalign_q;
  logic [AW-1:0]   e_addr [DEPTH];
  logic [XLEN-1:0] e_data [DEPTH];
  logic [NB-1:0]   e_mask [DEPTH];

  logic accept;
  logic push;
  logic pop;

  assign bus.st_ready = (count < CW'(DEPTH));
  assign accept       = bus.st_valid && bus.st_ready;
  assign push         = accept && !illegal;
  assign pop          = bus.mem_valid && bus.mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      vld        <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= accept && illegal;
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + PW'(1);
      end
      if (push) begin
        vld[tail] <= 1'b1;
        tail      <= tail + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Payload storage carries no reset; the valid bits and count alone define occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      e_addr[tail] <= req_addr;
      e_data[tail] <= req_data;
      e_mask[tail] <= req_mask;
    end
  end

  assign empty           = (count == '0);
  assign bus.mem_valid   = !empty;
  assign bus.mem_addr    = e_addr[head];
  assign bus.mem_data    = e_data[head];
  assign bus.mem_mask    = e_mask[head];
  assign bus.st_misalign = misalign_q;

  // Word-granular overlap check against every pending entry, mask ignored on purpose.
  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (e_addr[i][AW-1:LB] == ld_addr[AW-1:LB])) ld_conflict = 1'b1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.st_op[2], ld_addr[LB-1:0]};
endmodule
